hazard_ctrl_unit: RTL and testbench

//  Parametrised successor to the pipeline forwarding logic. Generates per-operand EX forwarding selects
//  for NSRC source operands, plus all pipeline enable/flush controls:
//   - load-use stall with a configurable number of bubbles;
//   - full freeze on data-memory wait;
//   - instruction-fetch miss bubble;
//   - taken-branch flush.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl_unit.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Pure type definitions: no latency, no flow control.
package hazard_pkg;

  localparam int RA_W_DEF = 5;

  typedef logic [RA_W_DEF-1:0] regbits_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One EX-operand forwarding slice; MEM result wins over WB, register 0 never forwards.
// Purely combinational, zero latency, no backpressure.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic            m_wen,
  input  logic [RA_W-1:0] m_wsel,
  input  logic            w_wen,
  input  logic [RA_W-1:0] w_wsel,
  output fwd_sel_t        sel
);

  always_comb begin
    sel = FWD_RF;
    if (m_wen && (m_wsel != '0) && (m_wsel == src)) begin
      sel = FWD_MEM;
    end else if (w_wen && (w_wsel != '0) && (w_wsel == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX forwarding selects plus PC/latch enables and flushes.
// Controls are combinational from inputs and FSM state; a data-memory miss freezes every stage.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int RA_W      = 5,
  parameter int NSRC      = 2,
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NSRC*RA_W-1:0] id_src_i,
  input  logic [NSRC-1:0]      id_use_i,
  input  logic [NSRC*RA_W-1:0] ex_src_i,
  input  logic                 ex_load_i,
  input  logic [RA_W-1:0]      ex_wsel_i,
  input  logic                 m_wen_i,
  input  logic [RA_W-1:0]      m_wsel_i,
  input  logic                 w_wen_i,
  input  logic [RA_W-1:0]      w_wsel_i,
  input  logic                 dmem_req_i,
  input  logic                 dhit_i,
  input  logic                 ihit_i,
  input  logic                 br_taken_i,
  output logic [NSRC*2-1:0]    forward_o,
  output logic                 pc_en_o,
  output logic                 ifid_en_o,
  output logic                 ifid_flush_o,
  output logic                 idex_en_o,
  output logic                 idex_flush_o,
  output logic                 exmem_en_o,
  output logic                 memwb_en_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     lu_cnt_o
);

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  localparam logic [6:0] CTL_ALL   = 7'b1101011;
  localparam logic [6:0] CTL_BR    = 7'b1111111;
  localparam logic [6:0] CTL_BUB   = 7'b0001111;
  localparam logic [6:0] CTL_IMISS = 7'b0111011;

  hz_state_t  state, state_nxt;
  logic [2:0] lu_left, lu_left_nxt;
  logic [6:0] ctl;
  logic       lu_hz, lu_evt, freeze;
  fwd_sel_t   sel [NSRC];

  for (genvar k = 0; k < NSRC; k++) begin : g_fwd
    hazard_fwd_sel #(.RA_W(RA_W)) u_sel (
      .src    (ex_src_i[k*RA_W +: RA_W]),
      .m_wen  (m_wen_i),
      .m_wsel (m_wsel_i),
      .w_wen  (w_wen_i),
      .w_wsel (w_wsel_i),
      .sel    (sel[k])
    );
    assign forward_o[k*2 +: 2] = nRST ? sel[k] : 2'b00;
  end

  always_comb begin
    lu_hz = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (id_use_i[k] && (id_src_i[k*RA_W +: RA_W] == ex_wsel_i)) lu_hz = 1'b1;
    end
    lu_hz = lu_hz && ex_load_i && (ex_wsel_i != '0);
  end

  // Once in MEM_WAIT only dhit releases the freeze, even if the request drops.
  always_comb begin
    ctl         = '0;
    state_nxt   = state;
    lu_left_nxt = lu_left;
    lu_evt      = 1'b0;
    freeze      = (state == MEM_WAIT) ? !dhit_i : (dmem_req_i && !dhit_i);
    if (state == LU_STALL) begin
      if (!freeze) begin
        ctl         = CTL_BUB;
        lu_left_nxt = lu_left - 3'd1;
        if (lu_left == 3'd1) state_nxt = RUN;
      end
    end else if (freeze) begin
      state_nxt = MEM_WAIT;
    end else begin
      state_nxt = RUN;
      if (br_taken_i) begin
        ctl = CTL_BR;
      end else if (lu_hz) begin
        ctl    = CTL_BUB;
        lu_evt = 1'b1;
        if (LU_CYCLES > 1) begin
          lu_left_nxt = 3'(LU_CYCLES - 1);
          state_nxt   = LU_STALL;
        end
      end else if (!ihit_i) begin
        ctl = CTL_IMISS;
      end else begin
        ctl = CTL_ALL;
      end
    end
  end

  assign {pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o, memwb_en_o} =
         nRST ? ctl : 7'b0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      lu_left     <= 3'd0;
      stall_cnt_o <= '0;
      lu_cnt_o    <= '0;
    end else begin
      state   <= state_nxt;
      lu_left <= lu_left_nxt;
      if (!ctl[6] && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (lu_evt && (lu_cnt_o != '1)) lu_cnt_o <= lu_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: three instances (LU_CYCLES 1/3/2, the last with 3-bit counters)
// share one stimulus stream; a reference model pushes expectations and a monitor compares each cycle.
module tb_hazard_ctrl_unit;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [9:0] id_src, ex_src;
  logic [1:0] id_use;
  logic       ex_load, m_wen, w_wen, dmem_req, dhit, ihit, br_taken;
  logic [4:0] ex_wsel, m_wsel, w_wsel;

  logic [3:0]  fwd1, fwd3, fwds;
  logic [6:0]  c1, c3, cs;
  logic [15:0] s1, l1, s3, l3;
  logic [2:0]  ss, ls;

  always #5 CLK = ~CLK;

  hazard_ctrl_unit #(.RA_W(5), .NSRC(2), .LU_CYCLES(1), .CNT_W(16)) u1 (
    .CLK(CLK), .nRST(nRST), .id_src_i(id_src), .id_use_i(id_use), .ex_src_i(ex_src),
    .ex_load_i(ex_load), .ex_wsel_i(ex_wsel), .m_wen_i(m_wen), .m_wsel_i(m_wsel),
    .w_wen_i(w_wen), .w_wsel_i(w_wsel), .dmem_req_i(dmem_req), .dhit_i(dhit), .ihit_i(ihit),
    .br_taken_i(br_taken), .forward_o(fwd1), .pc_en_o(c1[6]), .ifid_en_o(c1[5]),
    .ifid_flush_o(c1[4]), .idex_en_o(c1[3]), .idex_flush_o(c1[2]), .exmem_en_o(c1[1]),
    .memwb_en_o(c1[0]), .stall_cnt_o(s1), .lu_cnt_o(l1));

  hazard_ctrl_unit #(.RA_W(5), .NSRC(2), .LU_CYCLES(3), .CNT_W(16)) u3 (
    .CLK(CLK), .nRST(nRST), .id_src_i(id_src), .id_use_i(id_use), .ex_src_i(ex_src),
    .ex_load_i(ex_load), .ex_wsel_i(ex_wsel), .m_wen_i(m_wen), .m_wsel_i(m_wsel),
    .w_wen_i(w_wen), .w_wsel_i(w_wsel), .dmem_req_i(dmem_req), .dhit_i(dhit), .ihit_i(ihit),
    .br_taken_i(br_taken), .forward_o(fwd3), .pc_en_o(c3[6]), .ifid_en_o(c3[5]),
    .ifid_flush_o(c3[4]), .idex_en_o(c3[3]), .idex_flush_o(c3[2]), .exmem_en_o(c3[1]),
    .memwb_en_o(c3[0]), .stall_cnt_o(s3), .lu_cnt_o(l3));

  hazard_ctrl_unit #(.RA_W(5), .NSRC(2), .LU_CYCLES(2), .CNT_W(3)) us (
    .CLK(CLK), .nRST(nRST), .id_src_i(id_src), .id_use_i(id_use), .ex_src_i(ex_src),
    .ex_load_i(ex_load), .ex_wsel_i(ex_wsel), .m_wen_i(m_wen), .m_wsel_i(m_wsel),
    .w_wen_i(w_wen), .w_wsel_i(w_wsel), .dmem_req_i(dmem_req), .dhit_i(dhit), .ihit_i(ihit),
    .br_taken_i(br_taken), .forward_o(fwds), .pc_en_o(cs[6]), .ifid_en_o(cs[5]),
    .ifid_flush_o(cs[4]), .idex_en_o(cs[3]), .idex_flush_o(cs[2]), .exmem_en_o(cs[1]),
    .memwb_en_o(cs[0]), .stall_cnt_o(ss), .lu_cnt_o(ls));

  // Expected pipeline controls, ordered {pc, ifid, ifid_flush, idex, idex_flush, exmem, memwb}.
  localparam logic [6:0] E_ALL   = 7'b1101011;
  localparam logic [6:0] E_BR    = 7'b1111111;
  localparam logic [6:0] E_BUB   = 7'b0001111;
  localparam logic [6:0] E_IMISS = 7'b0111011;

  typedef struct packed {
    logic [3:0]  fwd;
    logic [6:0]  c1, c3, cs;
    logic [15:0] s1, l1, s3, l3;
    logic [2:0]  ss, ls;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  int LUP[3]  = '{1, 3, 2};
  int CMAX[3] = '{65535, 65535, 7};
  int m_bub[3], m_stall[3], m_lu[3];
  bit m_wait[3];

  function automatic logic [1:0] ref_fwd(input logic [4:0] s);
    if (m_wen && m_wsel != 5'd0 && m_wsel == s) return 2'b01;
    if (w_wen && w_wsel != 5'd0 && w_wsel == s) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ref_lu();
    bit h = 1'b0;
    for (int k = 0; k < 2; k++)
      if (id_use[k] && id_src[k*5 +: 5] == ex_wsel) h = 1'b1;
    return h && ex_load && (ex_wsel != 5'd0);
  endfunction

  // Model: an outstanding data miss freezes everything; pending load-use bubbles are
  // spent before any new decision; bubbles are not spent while frozen.
  task automatic model_ctl(input int i, input bit hz, output logic [6:0] c);
    bit frz;
    frz = m_wait[i] ? !dhit : (dmem_req && !dhit);
    c = 7'b0;
    if (frz) begin
      if (m_bub[i] == 0) m_wait[i] = 1'b1;
    end else begin
      m_wait[i] = 1'b0;
      if (m_bub[i] > 0) begin
        c = E_BUB;
        m_bub[i]--;
      end else if (br_taken) c = E_BR;
      else if (hz) begin
        c = E_BUB;
        if (m_lu[i] < CMAX[i]) m_lu[i]++;
        m_bub[i] = LUP[i] - 1;
      end else if (!ihit) c = E_IMISS;
      else c = E_ALL;
    end
    if (!c[6] && m_stall[i] < CMAX[i]) m_stall[i]++;
  endtask

  task automatic issue();
    exp_t       e;
    logic [6:0] c [3];
    bit         hz;
    if (!nRST) begin
      for (int i = 0; i < 3; i++) begin
        m_wait[i] = 1'b0; m_bub[i] = 0; m_stall[i] = 0; m_lu[i] = 0; c[i] = 7'b0;
      end
      e.fwd = 4'b0;
    end else begin
      e.fwd = {ref_fwd(ex_src[9:5]), ref_fwd(ex_src[4:0])};
    end
    e.s1 = 16'(m_stall[0]); e.l1 = 16'(m_lu[0]);
    e.s3 = 16'(m_stall[1]); e.l3 = 16'(m_lu[1]);
    e.ss = 3'(m_stall[2]);  e.ls = 3'(m_lu[2]);
    if (nRST) begin
      hz = ref_lu();
      for (int i = 0; i < 3; i++) model_ctl(i, hz, c[i]);
    end
    e.c1 = c[0]; e.c3 = c[1]; e.cs = c[2];
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle();
    id_src = '0; id_use = '0; ex_src = '0; ex_load = 1'b0; ex_wsel = '0;
    m_wen = 1'b0; m_wsel = '0; w_wen = 1'b0; w_wsel = '0;
    dmem_req = 1'b0; dhit = 1'b1; ihit = 1'b1; br_taken = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwd1", 16'(fwd1), 16'(e.fwd));
        chk("fwd3", 16'(fwd3), 16'(e.fwd));
        chk("fwds", 16'(fwds), 16'(e.fwd));
        chk("ctl1", 16'(c1), 16'(e.c1));
        chk("ctl3", 16'(c3), 16'(e.c3));
        chk("ctls", 16'(cs), 16'(e.cs));
        chk("stall1", s1, e.s1);
        chk("lu1", l1, e.l1);
        chk("stall3", s3, e.s3);
        chk("lu3", l3, e.l3);
        chk("stall_sat", 16'(ss), 16'(e.ss));
        chk("lu_sat", 16'(ls), 16'(e.ls));
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    idle();
    nRST = 1'b0;
    // Reset: outputs forced low even with matching forwarding inputs.
    repeat (2) begin
      next_cycle();
      m_wen = 1'b1; m_wsel = 5'd5; ex_src = {5'd5, 5'd5};
      issue();
    end
    // Forwarding priority and register-0 exclusion.
    next_cycle(); nRST = 1'b1; idle();
    m_wen = 1'b1; m_wsel = 5'd5; w_wen = 1'b1; w_wsel = 5'd5; ex_src[4:0] = 5'd5; issue();
    next_cycle(); m_wsel = 5'd0; issue();
    next_cycle(); ex_src[9:5] = 5'd0; w_wsel = 5'd0; issue();
    // Load-use hazard on operand 1, then consumer in EX with load in WB.
    next_cycle(); idle(); ex_load = 1'b1; ex_wsel = 5'd8; id_src[9:5] = 5'd8; id_use = 2'b10; issue();
    next_cycle(); idle(); w_wen = 1'b1; w_wsel = 5'd8; ex_src[9:5] = 5'd8; issue();
    repeat (3) begin next_cycle(); idle(); issue(); end
    next_cycle(); idle(); ex_load = 1'b1; ex_wsel = 5'd8; id_src[9:5] = 5'd8; id_use = 2'b00; issue();
    // Data miss with a taken branch pending, then the hit cycle.
    repeat (4) begin
      next_cycle(); idle(); dmem_req = 1'b1; dhit = 1'b0; br_taken = 1'b1; issue();
    end
    next_cycle(); idle(); dmem_req = 1'b1; dhit = 1'b1; br_taken = 1'b1; issue();
    // Instruction miss alone.
    next_cycle(); idle(); ihit = 1'b0; issue();
    // Reset in the middle of a multi-cycle load-use stall.
    next_cycle(); idle(); ex_load = 1'b1; ex_wsel = 5'd3; id_src[4:0] = 5'd3; id_use = 2'b01; issue();
    next_cycle(); idle(); nRST = 1'b0; issue();
    next_cycle(); issue();
    next_cycle(); nRST = 1'b1; issue();
    // Counter saturation on the narrow-counter instance.
    repeat (10) begin next_cycle(); idle(); ihit = 1'b0; issue(); end
    // Randomized traffic with small register numbers to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      nRST     = ($urandom_range(0, 499) != 0);
      id_src   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_use   = 2'($urandom_range(0, 3));
      ex_src   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_load  = ($urandom_range(0, 9) < 4);
      ex_wsel  = 5'($urandom_range(0, 7));
      m_wen    = $urandom_range(0, 1) == 1;
      m_wsel   = 5'($urandom_range(0, 7));
      w_wen    = $urandom_range(0, 1) == 1;
      w_wsel   = 5'($urandom_range(0, 7));
      dmem_req = ($urandom_range(0, 9) < 3);
      dhit     = ($urandom_range(0, 9) < 6);
      ihit     = ($urandom_range(0, 19) < 17);
      br_taken = ($urandom_range(0, 9) == 0);
      issue();
    end
    next_cycle(); nRST = 1'b1; idle();
    repeat (3) @(negedge CLK);
    chk("drain", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
